// File: rtl/fetch_decode_ctrl_if.sv
// Bus between the multicycle fetch/decode controller and its datapath:
// instruction memory port, decoded instruction fields, mux selects and strobes.
interface fetch_decode_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        Zero;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] SEin;
  logic [3:0]  FuncCode;
  logic        Regsel;
  logic        ALUsel;
  logic        MemToRegSel;
  logic [1:0]  ALUOp;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;

  modport master (
    output imem_addr, rs, rt, rd, SEin, FuncCode,
    output Regsel, ALUsel, MemToRegSel, ALUOp,
    output MemRead, MemWrite, RegWrite,
    input  imem_rdata, Zero
  );

  modport slave (
    input  imem_addr, rs, rt, rd, SEin, FuncCode,
    input  Regsel, ALUsel, MemToRegSel, ALUOp,
    input  MemRead, MemWrite, RegWrite,
    output imem_rdata, Zero
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Multicycle MIPS-subset controller: owns PC and IR, sequences FETCH/DECODE/EXEC/MEM/WB
// and drives datapath selects and strobes for R-type, addi, lw, sw, beq and j.
module fetch_decode_ctrl (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  fetch_decode_ctrl_if.master         bus,
  output logic                        instr_done,
  output logic                        illegal,
  output logic [2:0]                  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_regsel;
  logic        r_alusel;
  logic        r_memtoreg;
  logic [1:0]  r_aluop;

  logic [5:0]  w_op;
  logic        w_known;
  logic        w_dec_regsel;
  logic        w_dec_alusel;
  logic        w_dec_memtoreg;
  logic [1:0]  w_dec_aluop;
  logic [31:0] w_br_off;
  logic        w_memread;
  logic        w_memwrite;
  logic        w_regwrite;
  logic        w_done;
  logic        w_illegal;

  assign w_op     = r_ir[31:26];
  assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  always_comb begin
    w_known        = 1'b1;
    w_dec_regsel   = 1'b0;
    w_dec_alusel   = 1'b0;
    w_dec_memtoreg = 1'b0;
    w_dec_aluop    = 2'b00;
    case (w_op)
      OP_R: begin
        w_dec_regsel = 1'b1;
        w_dec_aluop  = 2'b10;
      end
      OP_ADDI: w_dec_alusel = 1'b1;
      OP_LW: begin
        w_dec_alusel   = 1'b1;
        w_dec_memtoreg = 1'b1;
      end
      OP_SW:   w_dec_alusel = 1'b1;
      OP_BEQ:  w_dec_aluop  = 2'b01;
      OP_J:    ;
      default: w_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = FETCH;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      FETCH: w_next = run ? DECODE : FETCH;
      DECODE: begin
        if (!w_known) begin
          w_illegal = 1'b1;
          w_done    = 1'b1;
        end else if (w_op == OP_J) begin
          w_done = 1'b1;
        end else begin
          w_next = EXEC;
        end
      end
      EXEC: begin
        if (w_op == OP_R || w_op == OP_ADDI) w_next = WB;
        else if (w_op == OP_LW || w_op == OP_SW) w_next = MEM;
        else w_done = 1'b1;
      end
      MEM: begin
        if (w_op == OP_LW) begin
          w_memread = 1'b1;
          w_next    = WB;
        end else begin
          w_memwrite = 1'b1;
          w_done     = 1'b1;
        end
      end
      WB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  // PC/IR updates: sequential fetch, jump at end of DECODE, taken branch at end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (r_state == FETCH && run) begin
        r_ir <= bus.imem_rdata;
        r_pc <= r_pc + 32'd4;
      end else if (r_state == DECODE && w_op == OP_J) begin
        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
      end else if (r_state == EXEC && w_op == OP_BEQ && bus.Zero) begin
        r_pc <= r_pc + w_br_off;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regsel   <= 1'b0;
      r_alusel   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_aluop    <= 2'b00;
    end else if (r_state == DECODE) begin
      r_regsel   <= w_dec_regsel;
      r_alusel   <= w_dec_alusel;
      r_memtoreg <= w_dec_memtoreg;
      r_aluop    <= w_dec_aluop;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.rs          = r_ir[25:21];
  assign bus.rt          = r_ir[20:16];
  assign bus.rd          = r_ir[15:11];
  assign bus.SEin        = r_ir[15:0];
  assign bus.FuncCode    = r_ir[3:0];
  assign bus.Regsel      = r_regsel;
  assign bus.ALUsel      = r_alusel;
  assign bus.MemToRegSel = r_memtoreg;
  assign bus.ALUOp       = r_aluop;
  assign bus.MemRead     = w_memread;
  assign bus.MemWrite    = w_memwrite;
  assign bus.RegWrite    = w_regwrite;
  assign instr_done      = w_done;
  assign illegal         = w_illegal;
  assign state           = r_state;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: walks addi, lw, beq, j, illegal, R-type and sw
// through the FSM, including an asynchronous reset that aborts a store.
module tb_fetch_decode_ctrl;
  logic       clk;
  logic       rst_n;
  logic       run;
  logic       instr_done;
  logic       illegal;
  logic [2:0] state;
  int         checks;
  int         errors;
  int         mw_count;

  fetch_decode_ctrl_if bus ();

  fetch_decode_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bus        (bus),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.MemWrite) mw_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr);
    bus.imem_rdata = instr;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; mw_count = 0;
    rst_n = 1'b0; run = 1'b0; bus.imem_rdata = '0; bus.Zero = 1'b0;
    #12;
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_state", state, 3'd0);
    chk("rst_regwrite", bus.RegWrite, 1'b0);
    chk("rst_done", instr_done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_rt", bus.rt, 5'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_addr", bus.imem_addr, 32'h0);

    // addi $5,$0,20 at PC 0
    fetch(32'h2005_0014);
    chk("addi_dec_state", state, 3'd1);
    chk("addi_pc", bus.imem_addr, 32'h4);
    chk("addi_rt", bus.rt, 5'd5);
    chk("addi_sein", bus.SEin, 16'h0014);
    tick();
    chk("addi_exec_state", state, 3'd2);
    chk("addi_alusel", bus.ALUsel, 1'b1);
    chk("addi_aluop", bus.ALUOp, 2'b00);
    chk("addi_exec_rw", bus.RegWrite, 1'b0);
    tick();
    chk("addi_wb_state", state, 3'd4);
    chk("addi_wb_rw", bus.RegWrite, 1'b1);
    chk("addi_wb_done", instr_done, 1'b1);
    tick();
    chk("addi_end_rw", bus.RegWrite, 1'b0);
    chk("addi_end_state", state, 3'd0);

    // lw at PC 4
    fetch(32'h8C0A_0028);
    chk("lw_pc", bus.imem_addr, 32'h8);
    chk("lw_rt", bus.rt, 5'd10);
    tick();
    chk("lw_memtoreg", bus.MemToRegSel, 1'b1);
    chk("lw_regsel", bus.Regsel, 1'b0);
    chk("lw_exec_mr", bus.MemRead, 1'b0);
    tick();
    chk("lw_mem_mr", bus.MemRead, 1'b1);
    chk("lw_mem_rw", bus.RegWrite, 1'b0);
    chk("lw_mem_done", instr_done, 1'b0);
    tick();
    chk("lw_wb_mr", bus.MemRead, 1'b0);
    chk("lw_wb_rw", bus.RegWrite, 1'b1);
    chk("lw_wb_done", instr_done, 1'b1);
    tick();
    chk("lw_end_state", state, 3'd0);

    // beq to self, taken
    fetch(32'h1000_FFFF);
    chk("beq_t_pc_dec", bus.imem_addr, 32'hC);
    bus.Zero = 1'b1;
    tick();
    chk("beq_t_state", state, 3'd2);
    chk("beq_t_aluop", bus.ALUOp, 2'b01);
    chk("beq_t_alusel", bus.ALUsel, 1'b0);
    chk("beq_t_done", instr_done, 1'b1);
    chk("beq_t_strobes", {bus.MemRead, bus.MemWrite, bus.RegWrite}, 3'b000);
    tick();
    chk("beq_t_pc", bus.imem_addr, 32'h8);
    chk("beq_t_end_state", state, 3'd0);

    // beq not taken
    bus.Zero = 1'b0;
    fetch(32'h1000_FFFF);
    tick();
    chk("beq_n_strobes", {bus.MemRead, bus.MemWrite, bus.RegWrite}, 3'b000);
    tick();
    chk("beq_n_pc", bus.imem_addr, 32'hC);

    // j 0x40
    fetch(32'h0800_0010);
    chk("j_done", instr_done, 1'b1);
    chk("j_pc_dec", bus.imem_addr, 32'h10);
    tick();
    chk("j_pc", bus.imem_addr, 32'h40);
    chk("j_state", state, 3'd0);

    // illegal opcode 0x3F
    fetch(32'hFC00_0000);
    chk("ill_pulse", illegal, 1'b1);
    chk("ill_done", instr_done, 1'b1);
    tick();
    chk("ill_clear", illegal, 1'b0);
    chk("ill_pc", bus.imem_addr, 32'h44);
    chk("ill_state", state, 3'd0);

    // add $8,$9,$10
    fetch(32'h012A_4020);
    chk("r_rs", bus.rs, 5'd9);
    chk("r_rd", bus.rd, 5'd8);
    chk("r_func", bus.FuncCode, 4'h0);
    tick();
    chk("r_regsel", bus.Regsel, 1'b1);
    chk("r_aluop", bus.ALUOp, 2'b10);
    tick();
    chk("r_wb_rw", bus.RegWrite, 1'b1);
    tick();
    chk("r_pc", bus.imem_addr, 32'h48);

    // sw, runs to completion
    fetch(32'hAC0A_0028);
    tick();
    chk("sw_exec_mw", bus.MemWrite, 1'b0);
    tick();
    chk("sw_mem_mw", bus.MemWrite, 1'b1);
    chk("sw_mem_done", instr_done, 1'b1);
    chk("sw_mem_rw", bus.RegWrite, 1'b0);
    tick();
    chk("sw_end_mw", bus.MemWrite, 1'b0);
    chk("sw_end_state", state, 3'd0);

    // sw aborted by reset during EXEC
    fetch(32'hAC0A_0028);
    tick();
    chk("swa_exec_state", state, 3'd2);
    mw_count = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("swa_rst_pc", bus.imem_addr, 32'h0);
    chk("swa_rst_state", state, 3'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_addr", bus.imem_addr, 32'h0);
    end
    chk("swa_no_mw", mw_count, 32'd0);
    fetch(32'h2005_0014);
    chk("refetch_pc", bus.imem_addr, 32'h4);
    chk("refetch_state", state, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
